// File: rtl/pdm_modulator.sv
// First-order sigma-delta pulse-density modulator: ones-density of pdm_out tracks data_in/(2^NBITS-1).
// Optional build macro PDM_INPUT_REG_EN adds an input capture register (latency 2 instead of 1).
module pdm_modulator #(
  parameter int NBITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] data_in,
  output logic             pdm_out,
  output logic [NBITS-1:0] pdm_error
);

  localparam logic [NBITS:0] M_EXT = {1'b0, {NBITS{1'b1}}};

  logic [NBITS-1:0] d;
  logic [NBITS-1:0] err_reg;
  logic [NBITS-1:0] err_next;
  logic             out_reg;
  logic             out_next;
  logic [NBITS:0]   err_ext;

`ifdef PDM_INPUT_REG_EN
  logic [NBITS-1:0] data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_in;
    end
  end

  assign d = data_reg;
`else
  assign d = data_in;
`endif

  // E stays in [0,M], so the NBITS+1 result never needs its top bit.
  always_comb begin
    out_next = 1'b0;
    err_ext  = {1'b0, err_reg} - {1'b0, d};
    if (d >= err_reg) begin
      out_next = 1'b1;
      err_ext  = {1'b0, err_reg} + M_EXT - {1'b0, d};
    end
    err_next = err_ext[NBITS-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= '0;
      out_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
      out_reg <= out_next;
    end
  end

  assign pdm_out   = out_reg;
  assign pdm_error = err_reg;

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed self-checking bench for pdm_modulator (NBITS=10): reset, first edges, density windows,
// boundary levels and asynchronous reset; expectations adjust when PDM_INPUT_REG_EN is defined.
module tb_pdm_modulator;

  localparam int NBITS = 10;
  localparam int M     = 1023;

  logic             clk;
  logic             rst;
  logic [NBITS-1:0] data_in;
  logic             pdm_out;
  logic [NBITS-1:0] pdm_error;

  int errors = 0;
  int checks = 0;
  int ones;
  int max_err;

  pdm_modulator #(.NBITS(NBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .pdm_out  (pdm_out),
    .pdm_error(pdm_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Counts ones and tracks the peak error over n cycles, sampling on falling edges.
  task automatic run_window(input int n);
    ones    = 0;
    max_err = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ones += int'(pdm_out);
      if (int'(pdm_error) > max_err) max_err = int'(pdm_error);
    end
  endtask

  task automatic do_reset(input logic [NBITS-1:0] level);
    @(negedge clk);
    rst     = 1'b0;
    data_in = level;
    @(negedge clk);
    rst     = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    data_in = 10'd120;

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_out", 32'(pdm_out), 32'd0);
      check("reset_err", 32'(pdm_error), 32'd0);
    end
    $display("step: reset hold done");

    // Release with d=120: first edges
    rst = 1'b1;
    @(negedge clk);
`ifdef PDM_INPUT_REG_EN
    check("first_out", 32'(pdm_out), 32'd1);
    check("first_err", 32'(pdm_error), 32'd1023);
    @(negedge clk);
    check("second_out", 32'(pdm_out), 32'd0);
    check("second_err", 32'(pdm_error), 32'd903);
`else
    check("first_out", 32'(pdm_out), 32'd1);
    check("first_err", 32'(pdm_error), 32'd903);
    @(negedge clk);
    check("second_out", 32'(pdm_out), 32'd0);
    check("second_err", 32'(pdm_error), 32'd783);
`endif
    run_window(M);
    check_range("density_120", ones, 119, 121);
    $display("step: d=120 ones=%0d", ones);

    // d=500 then d=900
    data_in = 10'd500;
    run_window(M);
    check_range("density_500", ones, 499, 501);
    check_range("maxerr_500", max_err, 0, M);
    $display("step: d=500 ones=%0d", ones);
    data_in = 10'd900;
    run_window(M);
    check_range("density_900", ones, 899, 901);
    check_range("maxerr_900", max_err, 0, M);
    $display("step: d=900 ones=%0d", ones);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_out", 32'(pdm_out), 32'd0);
    check("async_err", 32'(pdm_error), 32'd0);
    data_in = 10'd120;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`ifdef PDM_INPUT_REG_EN
    check("restart_err", 32'(pdm_error), 32'd1023);
`else
    check("restart_err", 32'(pdm_error), 32'd903);
`endif
    check("restart_out", 32'(pdm_out), 32'd1);
    $display("step: async reset and restart done");

    // d=M from reset: constant 1, E fixed
    do_reset(10'd1023);
    run_window(8);
    check("max_ones", 32'(ones), 32'd8);
`ifdef PDM_INPUT_REG_EN
    check("max_err", 32'(pdm_error), 32'd1023);
`else
    check("max_err", 32'(pdm_error), 32'd0);
`endif
    $display("step: d=1023 ones=%0d err=%0d", ones, pdm_error);

    // d=0 from reset: one 1, then zeros with E=M
    do_reset(10'd0);
    @(negedge clk);
    check("zero_first_out", 32'(pdm_out), 32'd1);
    check("zero_first_err", 32'(pdm_error), 32'd1023);
    run_window(20);
    check("zero_ones", 32'(ones), 32'd0);
    check("zero_err", 32'(pdm_error), 32'd1023);
    $display("step: d=0 ones=%0d err=%0d", ones, pdm_error);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
